// File: rtl/dragon_segment_scanner.sv
// Frame-rate collision scanner for the dragon body. Each vsync rise snapshots the seven
// segments and walks them one per clock against the player and sword tiles.
module dragon_segment_scanner #(
    parameter int NUM_SEG         = 7,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic [9:0]         Dragon_1,
    input  logic [9:0]         Dragon_2,
    input  logic [9:0]         Dragon_3,
    input  logic [9:0]         Dragon_4,
    input  logic [9:0]         Dragon_5,
    input  logic [9:0]         Dragon_6,
    input  logic [9:0]         Dragon_7,
    input  logic [NUM_SEG-1:0] Display_en,
    input  logic [7:0]         player_pos,
    input  logic [7:0]         sword_pos,
    input  logic               sword_valid,
    output logic               player_hit,
    output logic               segment_hit,
    output logic [2:0]         hit_index,
    output logic               scan_done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [3:0] CD_LOAD  = 4'(COOLDOWN_FRAMES);
    localparam logic [2:0] LAST_IDX = 3'(NUM_SEG);

    state_t               state_q, state_d;
    logic                 vsync_q;
    logic [2:0]           idx_q;
    logic [7:0]           pos_q [NUM_SEG];
    logic [NUM_SEG-1:0]   en_q;
    logic [7:0]           ppos_q, spos_q;
    logic                 svalid_q, cd_zero_q;
    logic                 pflag_q, sflag_q;
    logic [2:0]           sidx_q;
    logic [3:0]           cooldown_q;
    logic                 player_hit_q, segment_hit_q, scan_done_q;
    logic [2:0]           hit_index_q;

    logic [7:0]           seg_pos [NUM_SEG];
    logic                 rise;
    logic [2:0]           sel;
    logic [7:0]           cur_pos;
    logic                 cur_en, p_match, s_match;
    logic                 unused_orient;

    assign seg_pos[0] = Dragon_1[7:0];
    assign seg_pos[1] = Dragon_2[7:0];
    assign seg_pos[2] = Dragon_3[7:0];
    assign seg_pos[3] = Dragon_4[7:0];
    assign seg_pos[4] = Dragon_5[7:0];
    assign seg_pos[5] = Dragon_6[7:0];
    assign seg_pos[6] = Dragon_7[7:0];

    // Orientation plays no part in collision.
    assign unused_orient = ^{Dragon_1[9:8], Dragon_2[9:8], Dragon_3[9:8], Dragon_4[9:8],
                             Dragon_5[9:8], Dragon_6[9:8], Dragon_7[9:8]};

    assign rise    = vsync & ~vsync_q;
    assign sel     = idx_q - 3'd1;
    assign cur_pos = pos_q[sel];
    assign cur_en  = en_q[sel];
    assign p_match = cur_en && (cur_pos == ppos_q);
    // cd_zero_q holds the cooldown as seen before this frame's decrement.
    assign s_match = cur_en && svalid_q && cd_zero_q && !sflag_q && (cur_pos == spos_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            idx_q         <= 3'd0;
            for (int i = 0; i < NUM_SEG; i++) pos_q[i] <= 8'd0;
            en_q          <= '0;
            ppos_q        <= 8'd0;
            spos_q        <= 8'd0;
            svalid_q      <= 1'b0;
            cd_zero_q     <= 1'b0;
            pflag_q       <= 1'b0;
            sflag_q       <= 1'b0;
            sidx_q        <= 3'd0;
            cooldown_q    <= 4'd0;
            player_hit_q  <= 1'b0;
            segment_hit_q <= 1'b0;
            scan_done_q   <= 1'b0;
            hit_index_q   <= 3'd0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            player_hit_q  <= 1'b0;
            segment_hit_q <= 1'b0;
            scan_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        for (int i = 0; i < NUM_SEG; i++) pos_q[i] <= seg_pos[i];
                        en_q      <= Display_en;
                        ppos_q    <= player_pos;
                        spos_q    <= sword_pos;
                        svalid_q  <= sword_valid;
                        cd_zero_q <= (cooldown_q == 4'd0);
                        idx_q     <= 3'd1;
                        pflag_q   <= 1'b0;
                        sflag_q   <= 1'b0;
                        sidx_q    <= 3'd0;
                        if (cooldown_q != 4'd0) cooldown_q <= cooldown_q - 4'd1;
                    end
                end
                SCAN: begin
                    if (p_match) pflag_q <= 1'b1;
                    if (s_match) begin
                        sflag_q <= 1'b1;
                        sidx_q  <= idx_q;
                    end
                    idx_q <= idx_q + 3'd1;
                end
                REPORT: begin
                    player_hit_q  <= pflag_q;
                    segment_hit_q <= sflag_q;
                    scan_done_q   <= 1'b1;
                    hit_index_q   <= sflag_q ? sidx_q : 3'd0;
                    if (sflag_q) cooldown_q <= CD_LOAD;
                end
                default: ;
            endcase
        end
    end

    assign player_hit  = player_hit_q;
    assign segment_hit = segment_hit_q;
    assign hit_index   = hit_index_q;
    assign scan_done   = scan_done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dragon_segment_scanner.sv
// Bench for dragon_segment_scanner: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level collision model.
module tb_dragon_segment_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] dr [7];
    logic [6:0] en = 7'd0;
    logic [7:0] pp = 8'hF0;
    logic [7:0] sp = 8'hF1;
    logic       sv = 1'b0;
    logic       player_hit, segment_hit, scan_done, busy;
    logic [2:0] hit_index;

    int         total = 0;
    int         bad = 0;
    int         cd_m = 0;
    logic [2:0] prev_idx = 3'd0;

    typedef struct {
        string           name;
        logic [6:0][9:0] d;
        logic [6:0]      en;
        logic [7:0]      pp, sp;
        logic            sv;
        logic            ep, es;
        logic [2:0]      ei;
    } vec_t;

    vec_t vt [8];

    dragon_segment_scanner #(.NUM_SEG(7), .COOLDOWN_FRAMES(4)) dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .Dragon_1(dr[0]), .Dragon_2(dr[1]), .Dragon_3(dr[2]), .Dragon_4(dr[3]),
        .Dragon_5(dr[4]), .Dragon_6(dr[5]), .Dragon_7(dr[6]),
        .Display_en(en), .player_pos(pp), .sword_pos(sp), .sword_valid(sv),
        .player_hit(player_hit), .segment_hit(segment_hit), .hit_index(hit_index),
        .scan_done(scan_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0][9:0] dflt();
        logic [6:0][9:0] d;
        for (int k = 0; k < 7; k++) d[k] = 10'(8'hC1 + k);
        return d;
    endfunction

    // Frame-level model: any enabled segment on the player tile; lowest enabled segment on
    // the sword tile, only if the cooldown was already zero when the frame began.
    task automatic model(input logic [6:0][9:0] d, input logic [6:0] e, input logic [7:0] p_pos,
                         input logic [7:0] s_pos, input logic s_v,
                         output logic ep, output logic es, output logic [2:0] ei);
        bit open;
        open = (cd_m == 0);
        ep = 1'b0; es = 1'b0; ei = 3'd0;
        if (cd_m > 0) cd_m--;
        for (int k = 0; k < 7; k++) begin
            if (e[k]) begin
                if (d[k][7:0] == p_pos) ep = 1'b1;
                if (open && s_v && !es && d[k][7:0] == s_pos) begin
                    es = 1'b1;
                    ei = 3'(k + 1);
                end
            end
        end
        if (es) cd_m = 4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cd_m = 0;
        prev_idx = 3'd0;
    endtask

    task automatic do_frame(input string tag, input logic [6:0][9:0] d, input logic [6:0] e,
                            input logic [7:0] p_pos, input logic [7:0] s_pos, input logic s_v,
                            output logic got_p, output logic got_s);
        logic ep, es;
        logic [2:0] ei;
        @(negedge clk);
        for (int k = 0; k < 7; k++) dr[k] = d[k];
        en = e; pp = p_pos; sp = s_pos; sv = s_v;
        vsync = 1'b1;
        model(d, e, p_pos, s_pos, s_v, ep, es, ei);
        @(negedge clk);
        vsync = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        repeat (7) @(negedge clk);
        chk({tag, "_done_early"}, scan_done, 0);
        chk({tag, "_idx_hold"}, hit_index, prev_idx);
        @(negedge clk);
        got_p = player_hit;
        got_s = segment_hit;
        chk({tag, "_done"}, scan_done, 1);
        chk({tag, "_player"}, player_hit, ep);
        chk({tag, "_sword"}, segment_hit, es);
        chk({tag, "_idx"}, hit_index, ei);
        chk({tag, "_busy_end"}, busy, 0);
        prev_idx = es ? ei : 3'd0;
        @(negedge clk);
        chk({tag, "_done_one"}, scan_done, 0);
        chk({tag, "_sword_one"}, segment_hit, 0);
        chk({tag, "_idx_after"}, hit_index, prev_idx);
    endtask

    initial begin
        logic gp, gs;
        logic [6:0][9:0] d;
        int n_done, n_bad;
        logic p_seen, s_seen;
        logic [2:0] i_seen;

        for (int k = 0; k < 7; k++) dr[k] = 10'(8'hC1 + k);

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_outputs", {player_hit, segment_hit, hit_index, scan_done, busy}, 0);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outputs", {player_hit, segment_hit, hit_index, scan_done, busy}, 0);
        end

        // Vector table
        for (int i = 0; i < 8; i++) begin
            vt[i].d = dflt(); vt[i].pp = 8'hF0; vt[i].sp = 8'hF1; vt[i].sv = 1'b1; vt[i].en = 7'h7F;
        end
        vt[0].name = "basic";  vt[0].en = 7'b0000111; vt[0].d[2] = 10'h045; vt[0].sp = 8'h45;
        vt[0].ep = 0; vt[0].es = 1; vt[0].ei = 3;
        vt[1].name = "prio5";  vt[1].d[1] = 10'h021; vt[1].d[4] = 10'h021; vt[1].en = 7'b0010000;
        vt[1].sp = 8'h21; vt[1].ep = 0; vt[1].es = 1; vt[1].ei = 5;
        vt[2].name = "prio2";  vt[2].d[1] = 10'h021; vt[2].d[4] = 10'h021; vt[2].en = 7'b0010010;
        vt[2].sp = 8'h21; vt[2].ep = 0; vt[2].es = 1; vt[2].ei = 2;
        vt[3].name = "noen";   vt[3].d[0] = 10'h033; vt[3].pp = 8'h33; vt[3].sp = 8'h33; vt[3].en = 7'd0;
        vt[3].ep = 0; vt[3].es = 0; vt[3].ei = 0;
        vt[4].name = "novalid"; vt[4].d[6] = 10'h05A; vt[4].pp = 8'h5A; vt[4].sp = 8'h5A; vt[4].sv = 1'b0;
        vt[4].ep = 1; vt[4].es = 0; vt[4].ei = 0;
        vt[5].name = "simul";  vt[5].d[0] = 10'h077; vt[5].pp = 8'h77; vt[5].sp = 8'h77;
        vt[5].ep = 1; vt[5].es = 1; vt[5].ei = 1;
        vt[6].name = "orient"; vt[6].d[3] = 10'h3AA; vt[6].d[5] = 10'h1AA; vt[6].sp = 8'hAA;
        vt[6].ep = 0; vt[6].es = 1; vt[6].ei = 4;
        vt[7].name = "split";  vt[7].d[5] = 10'h0B0; vt[7].pp = 8'hB0; vt[7].d[6] = 10'h2B1; vt[7].sp = 8'hB1;
        vt[7].ep = 1; vt[7].es = 1; vt[7].ei = 7;
        for (int i = 0; i < 8; i++) begin
            do_reset();
            do_frame(vt[i].name, vt[i].d, vt[i].en, vt[i].pp, vt[i].sp, vt[i].sv, gp, gs);
            chk({vt[i].name, "_tbl_player"}, gp, vt[i].ep);
            chk({vt[i].name, "_tbl_sword"}, gs, vt[i].es);
            chk({vt[i].name, "_tbl_idx"}, hit_index, vt[i].ei);
        end

        // Cooldown: persistent sword match hits on frames 1 and 6 only
        do_reset();
        d = dflt(); d[0] = 10'h040;
        for (int f = 1; f <= 7; f++) begin
            do_frame("cd", d, 7'h7F, (f == 3) ? 8'h40 : 8'hF0, 8'h40, 1'b1, gp, gs);
            chk("cd_frame_sword", gs, (f == 1 || f == 6) ? 1 : 0);
            if (f == 3) chk("cd_frame3_player", gp, 1);
        end

        // Mid-scan input change plus a second vsync rise while busy
        do_reset();
        @(negedge clk);
        d = dflt(); d[0] = 10'h077; d[1] = 10'h055;
        for (int k = 0; k < 7; k++) dr[k] = d[k];
        en = 7'h7F; pp = 8'h77; sp = 8'h77; sv = 1'b1; vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        dr[0] = 10'h000; pp = 8'h55; sp = 8'h66; vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        n_done = 0; p_seen = 0; s_seen = 0; i_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (scan_done) begin
                n_done++;
                p_seen = player_hit; s_seen = segment_hit; i_seen = hit_index;
            end
        end
        chk("ms_done_count", n_done, 1);
        chk("ms_player", p_seen, 1);
        chk("ms_sword", s_seen, 1);
        chk("ms_idx", i_seen, 1);

        // Reset in the middle of a scan
        do_reset();
        @(negedge clk);
        d = dflt(); d[1] = 10'h012;
        for (int k = 0; k < 7; k++) dr[k] = d[k];
        en = 7'h7F; pp = 8'hF0; sp = 8'h12; sv = 1'b1; vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rm_async", {player_hit, segment_hit, hit_index, scan_done, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        cd_m = 0; prev_idx = 3'd0;
        n_bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (scan_done || segment_hit || player_hit || busy) n_bad++;
        end
        chk("rm_no_pulse", n_bad, 0);
        do_frame("rm_next", d, 7'h7F, 8'hF0, 8'h12, 1'b1, gp, gs);
        chk("rm_next_sword", gs, 1);

        // Randomized frames
        do_reset();
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 7; k++) d[k] = {2'($urandom), 8'($urandom_range(0, 7))};
            do_frame("rnd", d, 7'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) != 0), gp, gs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
